// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, frame-length helper and sync-lock state encoding.
package vga_timing_pkg;

    // Default 640x480 timing, shared with the generator side.
    localparam int DEF_HRES = 640;
    localparam int DEF_HF   = 16;
    localparam int DEF_HS   = 96;
    localparam int DEF_HB   = 48;
    localparam int DEF_VRES = 480;
    localparam int DEF_VF   = 10;
    localparam int DEF_VS   = 2;
    localparam int DEF_VB   = 33;

    // Position counters are 10 bits wide on both axes.
    localparam int POS_W = 10;

    // Total line or frame length from its four timing segments.
    function automatic int full_len(input int active, input int fp, input int pw, input int bp);
        return active + fp + pw + bp;
    endfunction

    localparam int DEF_HFULL = full_len(DEF_HRES, DEF_HF, DEF_HS, DEF_HB);
    localparam int DEF_VFULL = full_len(DEF_VRES, DEF_VF, DEF_VS, DEF_VB);

    // Lock progression: find hsync, find vsync, prove clean frames, then track.
    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        HALIGN = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } lock_state_t;

endpackage

// File: rtl/vga_sync_expect.sv
// Maps a raster position to the sync levels and visible flag a generator
// would produce there; shared between the generator and the lock checker.
module vga_sync_expect
    import vga_timing_pkg::*;
#(
    parameter int HRES = DEF_HRES,
    parameter int HF   = DEF_HF,
    parameter int HS   = DEF_HS,
    parameter int VRES = DEF_VRES,
    parameter int VF   = DEF_VF,
    parameter int VS   = DEF_VS
) (
    input  logic [POS_W-1:0] h,
    input  logic [POS_W-1:0] v,
    output logic             exp_hs,
    output logic             exp_vs,
    output logic             in_visible
);

    localparam logic [POS_W-1:0] HS_START = POS_W'(HRES + HF);
    localparam logic [POS_W-1:0] HS_END   = POS_W'(HRES + HF + HS);
    localparam logic [POS_W-1:0] VS_START = POS_W'(VRES + VF);
    localparam logic [POS_W-1:0] VS_END   = POS_W'(VRES + VF + VS);
    localparam logic [POS_W-1:0] H_VIS    = POS_W'(HRES);
    localparam logic [POS_W-1:0] V_VIS    = POS_W'(VRES);

    // Syncs are active-low inside their pulse window; visible is the active area.
    always_comb begin
        exp_hs     = ~((h >= HS_START) && (h < HS_END));
        exp_vs     = ~((v >= VS_START) && (v < VS_END));
        in_visible = (h < H_VIS) && (v < V_VIS);
    end

endmodule

// File: rtl/vga_sync_lock.sv
// Recovers raster position from an active-low hsync/vsync pair and declares
// lock after a number of clean frames; any later deviation drops lock.
module vga_sync_lock
    import vga_timing_pkg::*;
#(
    parameter int HRES        = DEF_HRES,
    parameter int HF          = DEF_HF,
    parameter int HS          = DEF_HS,
    parameter int HB          = DEF_HB,
    parameter int VRES        = DEF_VRES,
    parameter int VF          = DEF_VF,
    parameter int VS          = DEF_VS,
    parameter int VB          = DEF_VB,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    output logic [POS_W-1:0] h,
    output logic [POS_W-1:0] v,
    output logic             visible,
    output logic             locked,
    output logic             frame_start,
    output logic             sync_err
);

    localparam int HFULL = full_len(HRES, HF, HS, HB);
    localparam int VFULL = full_len(VRES, VF, VS, VB);
    localparam int CNT_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [POS_W-1:0] H_LAST       = POS_W'(HFULL - 1);
    localparam logic [POS_W-1:0] V_LAST       = POS_W'(VFULL - 1);
    // The hsync fall is seen while the generator sits at HRES+HF, so the
    // register must take the value the generator shows one cycle later.
    localparam logic [POS_W-1:0] H_SEEK_LOAD  = POS_W'(HRES + HF + 1);
    // The vsync fall is seen at h==0 of line VRES+VF; v already holds that
    // line on the generator, so the load keeps it for the rest of the line.
    localparam logic [POS_W-1:0] V_ALIGN_LOAD = POS_W'(VRES + VF);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(LOCK_FRAMES - 1);

    lock_state_t      state;
    lock_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [POS_W-1:0] h_next;
    logic [POS_W-1:0] v_next;
    logic             err_next;

    logic hs_q;
    logic vs_q;
    logic hs_low_at_reset;
    logic vs_low_at_reset;
    logic hs_fall;
    logic vs_fall;

    logic exp_hs;
    logic exp_vs;
    logic in_visible;
    logic hmax;
    logic vmax;
    logic hmis;
    logic vmis;

    vga_sync_expect #(
        .HRES (HRES),
        .HF   (HF),
        .HS   (HS),
        .VRES (VRES),
        .VF   (VF),
        .VS   (VS)
    ) u_expect (
        .h          (h),
        .v          (v),
        .exp_hs     (exp_hs),
        .exp_vs     (exp_vs),
        .in_visible (in_visible)
    );

    // Previous-cycle sync levels; a sync already low while reset is applied
    // is remembered so that its release is not mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q            <= 1'b1;
            vs_q            <= 1'b1;
            hs_low_at_reset <= ~hsync;
            vs_low_at_reset <= ~vsync;
        end else begin
            hs_q            <= hsync;
            vs_q            <= vsync;
            hs_low_at_reset <= 1'b0;
            vs_low_at_reset <= 1'b0;
        end
    end

    // Edge detection, counter wrap points and comparison against expected syncs.
    always_comb begin
        hs_fall = hs_q && !hsync && !hs_low_at_reset;
        vs_fall = vs_q && !vsync && !vs_low_at_reset;
        hmax    = (h == H_LAST);
        vmax    = (v == V_LAST);
        hmis    = (hsync != exp_hs);
        vmis    = (vsync != exp_vs);
    end

    // Free-running counters with alignment loads, and the lock state machine;
    // mismatches take priority over wraps and lock transitions.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = 1'b0;
        h_next     = hmax ? '0 : h + 1'b1;
        v_next     = v;
        if (hmax) begin
            v_next = vmax ? '0 : v + 1'b1;
        end

        unique case (state)
            SEEK: begin
                if (hs_fall) begin
                    h_next     = H_SEEK_LOAD;
                    state_next = HALIGN;
                end
            end
            HALIGN: begin
                if (hmis) begin
                    state_next = SEEK;
                end else if (vs_fall) begin
                    if (h == '0) begin
                        v_next     = V_ALIGN_LOAD;
                        cnt_next   = '0;
                        state_next = CHECK;
                    end else begin
                        state_next = SEEK;
                    end
                end
            end
            CHECK: begin
                if (hmis || vmis) begin
                    state_next = SEEK;
                end else if (hmax && vmax) begin
                    if (cnt == CNT_LAST) begin
                        state_next = LOCKED;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (hmis || vmis) begin
                    state_next = SEEK;
                    err_next   = 1'b1;
                end
            end
            default: begin
                state_next = SEEK;
            end
        endcase
    end

    // State, frame counter, position registers and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEEK;
            cnt      <= '0;
            h        <= '0;
            v        <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            h        <= h_next;
            v        <= v_next;
            sync_err <= err_next;
        end
    end

    // Lock status follows the state register; the rest decode from it and h/v.
    always_comb begin
        locked      = (state == LOCKED);
        visible     = locked && in_visible;
        frame_start = locked && (h == '0) && (v == '0);
    end

endmodule

// File: tb/tb_vga_sync_lock.sv
// Directed bench for vga_sync_lock using a small raster and a behavioural
// sync generator that can be mistimed, glitched and reset independently.
`timescale 1ns/1ps
module tb_vga_sync_lock;
    import vga_timing_pkg::*;

    localparam int T_HRES  = 16;
    localparam int T_HF    = 2;
    localparam int T_HS    = 3;
    localparam int T_HB    = 3;
    localparam int T_VRES  = 8;
    localparam int T_VF    = 2;
    localparam int T_VS    = 2;
    localparam int T_VB    = 2;
    localparam int T_HFULL = 24;
    localparam int T_VFULL = 14;
    localparam int T_FRAME = T_HFULL * T_VFULL;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] h;
    logic [9:0] v;
    logic       visible;
    logic       locked;
    logic       frame_start;
    logic       sync_err;

    int gen_h  = 0;
    int gen_v  = 0;
    int gen_hb = T_HB;
    bit force_hs_high = 1'b0;
    bit force_vs_low  = 1'b0;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    vga_sync_lock #(
        .HRES        (T_HRES),
        .HF          (T_HF),
        .HS          (T_HS),
        .HB          (T_HB),
        .VRES        (T_VRES),
        .VF          (T_VF),
        .VS          (T_VS),
        .VB          (T_VB),
        .LOCK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .h           (h),
        .v           (v),
        .visible     (visible),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic drive_syncs();
        hsync = !((gen_h >= T_HRES + T_HF) && (gen_h < T_HRES + T_HF + T_HS));
        vsync = !((gen_v >= T_VRES + T_VF) && (gen_v < T_VRES + T_VF + T_VS));
        if (force_hs_high) hsync = 1'b1;
        if (force_vs_low)  vsync = 1'b0;
        force_hs_high = 1'b0;
        force_vs_low  = 1'b0;
    endtask

    task automatic advance_gen();
        if (gen_h == T_HRES + T_HF + T_HS + gen_hb - 1) begin
            gen_h = 0;
            gen_v = (gen_v == T_VFULL - 1) ? 0 : gen_v + 1;
        end else begin
            gen_h = gen_h + 1;
        end
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        reset = 1'b0;
        advance_gen();
        drive_syncs();
        cyc = cyc + 1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s at cycle %0d: observed 0x%0h, expected 0x%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic apply_joint_reset(input int hb);
        reset  = 1'b1;
        gen_hb = hb;
        gen_h  = 0;
        gen_v  = 0;
        drive_syncs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_until(input int th, input int tv);
        int n = 0;
        while (!(gen_h == th && gen_v == tv) && n < 1000) begin
            apply_stimulus();
            n = n + 1;
        end
        check_output("reach_position", {31'd0, (gen_h == th && gen_v == tv)}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_h"}, 32'(h), 32'd0);
        check_output({tag, "_v"}, 32'(v), 32'd0);
        check_output({tag, "_visible"}, 32'(visible), 32'd0);
        check_output({tag, "_locked"}, 32'(locked), 32'd0);
        check_output({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check_output({tag, "_sync_err"}, 32'(sync_err), 32'd0);
        check_output({tag, "_state"}, 32'(dut.state), 32'(SEEK));
    endtask

    task automatic expect_lock_sequence(input int line);
        run_until(T_HRES + T_HF, line);
        check_output("seek_at_hfall", 32'(dut.state), 32'(SEEK));
        apply_stimulus();
        check_output("halign_entry", 32'(dut.state), 32'(HALIGN));
        check_output("halign_h_load", 32'(h), 32'(T_HRES + T_HF + 1));
        run_until(0, T_VRES + T_VF);
        check_output("halign_at_vfall", 32'(dut.state), 32'(HALIGN));
        apply_stimulus();
        check_output("check_entry", 32'(dut.state), 32'(CHECK));
        check_output("check_v_load", 32'(v), 32'(T_VRES + T_VF));
        check_output("check_h", 32'(h), 32'd1);
        run_until(T_HFULL - 1, T_VFULL - 1);
        apply_stimulus();
        run_until(T_HFULL - 1, T_VFULL - 1);
        check_output("pre_lock_locked", 32'(locked), 32'd0);
        check_output("pre_lock_state", 32'(dut.state), 32'(CHECK));
        apply_stimulus();
        check_output("lock_locked", 32'(locked), 32'd1);
        check_output("lock_hv", {12'd0, h, v}, 32'd0);
        check_output("lock_frame_start", 32'(frame_start), 32'd1);
        check_output("lock_sync_err", 32'(sync_err), 32'd0);
    endtask

    task automatic track_frames(input int frames);
        logic exp_vis;
        logic exp_fs;
        for (int i = 0; i < frames * T_FRAME; i++) begin
            apply_stimulus();
            exp_vis = (gen_h < T_HRES) && (gen_v < T_VRES);
            exp_fs  = (gen_h == 0) && (gen_v == 0);
            check_output("track", {8'd0, h, v, visible, locked, sync_err, frame_start},
                         {8'd0, 10'(gen_h), 10'(gen_v), exp_vis, 1'b1, 1'b0, exp_fs});
        end
    endtask

    initial begin
        lock_state_t prev_state;
        int halign_entries;

        $display("[TB] clean lock after joint reset");
        apply_joint_reset(T_HB);
        check_reset_outputs("reset");
        expect_lock_sequence(0);
        track_frames(3);

        $display("[TB] reset released mid-frame");
        run_until(9, 5);
        reset = 1'b1;
        apply_stimulus();
        cyc = 0;
        check_reset_outputs("midreset");
        expect_lock_sequence(5);
        track_frames(1);

        $display("[TB] single-cycle hsync deviation while locked");
        run_until(T_HRES + T_HF, 3);
        force_hs_high = 1'b1;
        apply_stimulus();
        check_output("glitch_cycle_locked", 32'(locked), 32'd1);
        check_output("glitch_cycle_err", 32'(sync_err), 32'd0);
        apply_stimulus();
        check_output("drop_locked", 32'(locked), 32'd0);
        check_output("drop_sync_err", 32'(sync_err), 32'd1);
        check_output("drop_state", 32'(dut.state), 32'(SEEK));
        apply_stimulus();
        check_output("err_one_cycle", 32'(sync_err), 32'd0);
        run_until(0, T_VRES + T_VF);
        check_output("realign_halign", 32'(dut.state), 32'(HALIGN));
        run_until(T_HFULL - 1, T_VFULL - 1);
        apply_stimulus();
        run_until(T_HFULL - 1, T_VFULL - 1);
        check_output("relock_pre", 32'(locked), 32'd0);
        apply_stimulus();
        check_output("relock_locked", 32'(locked), 32'd1);
        check_output("relock_frame_start", 32'(frame_start), 32'd1);

        $display("[TB] generator with short back porch");
        apply_joint_reset(T_HB - 1);
        halign_entries = 0;
        prev_state = dut.state;
        for (int i = 0; i < 3 * (T_HFULL - 1) * T_VFULL; i++) begin
            apply_stimulus();
            if (prev_state == SEEK && dut.state == HALIGN) halign_entries = halign_entries + 1;
            prev_state = dut.state;
            check_output("mistimed_no_lock",
                         {29'd0, locked, sync_err, (dut.state == CHECK || dut.state == LOCKED)}, 32'd0);
        end
        check_output("mistimed_halign_entries", {31'd0, (halign_entries >= 14)}, 32'd1);

        $display("[TB] vsync glitch during CHECK");
        apply_joint_reset(T_HB);
        run_until(T_HFULL - 1, T_VFULL - 1);
        apply_stimulus();
        run_until(4, 3);
        check_output("glitch_in_check", 32'(dut.state), 32'(CHECK));
        force_vs_low = 1'b1;
        apply_stimulus();
        apply_stimulus();
        check_output("vglitch_seek", 32'(dut.state), 32'(SEEK));
        run_until(0, 0);
        check_output("vglitch_not_locked_clean_time", 32'(locked), 32'd0);
        run_until(T_HFULL - 1, T_VFULL - 1);
        check_output("vglitch_pre_lock", 32'(locked), 32'd0);
        apply_stimulus();
        check_output("vglitch_lock", 32'(locked), 32'd1);
        check_output("vglitch_frame_start", 32'(frame_start), 32'd1);

        $display("[TB] reset pulse while locked with hsync low");
        run_until(T_HRES + T_HF + 1, 2);
        check_output("pulse_pre_locked", 32'(locked), 32'd1);
        reset = 1'b1;
        apply_stimulus();
        check_reset_outputs("pulse");
        apply_stimulus();
        check_output("pulse_no_false_edge", 32'(dut.state), 32'(SEEK));
        run_until(T_HRES + T_HF, 3);
        check_output("pulse_still_seek", 32'(dut.state), 32'(SEEK));
        apply_stimulus();
        check_output("pulse_genuine_edge", 32'(dut.state), 32'(HALIGN));
        check_output("pulse_h_load", 32'(h), 32'(T_HRES + T_HF + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
